uart_alu_seq_ctrl: RTL

//  Sequencer between UART receiver, ALU and UART transmitter. Collects three

---
 rtl/uart_alu_seq_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_alu_seq_ctrl.sv
// uart_alu_seq_ctrl
// Sequencer between a UART receiver, a combinational ALU and a UART transmitter.
// It gathers operand A, operand B and the opcode from three received bytes,
// presents them to the ALU, and captures the result. It then starts the
// transmitter and waits for TX_DONE. An inter-byte timeout, counted in baud
// ticks, abandons a partial command so the stream can resynchronise.

module uart_alu_seq_ctrl #(
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned OP_W          = 6,
   parameter int unsigned TIMEOUT_TICKS = 4096
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              TICK,
   input  logic              RX_DONE,
   input  logic [DATA_W-1:0] RX_DATA,
   input  logic [DATA_W-1:0] ALU_RESULT,
   input  logic              TX_DONE,
   output logic [DATA_W-1:0] ALU_A,
   output logic [DATA_W-1:0] ALU_B,
   output logic [OP_W-1:0]   ALU_OP,
   output logic [DATA_W-1:0] TX_DATA,
   output logic              TX_START,
   output logic              BUSY,
   output logic              ERR_TIMEOUT,
   output logic              ERR_OVERRUN,
   output logic [2:0]        STATE
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_TICKS + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GET_B   = 3'd1,
      S_GET_OP  = 3'd2,
      S_EXEC    = 3'd3,
      S_SEND    = 3'd4,
      S_WAIT_TX = 3'd5
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_alu_a;
   logic [DATA_W-1:0]   r_alu_b;
   logic [OP_W-1:0]     r_alu_op;
   logic [DATA_W-1:0]   r_tx_data;
   logic                r_tx_start;
   logic                r_err_timeout;
   logic                r_err_overrun;

   logic [CNT_W-1:0]    w_cnt_next;
   logic                w_cnt_term;

   // Next tick count and whether a tick now would reach the timeout limit
   always_comb begin
      w_cnt_next = r_cnt + 1'b1;
      w_cnt_term = (w_cnt_next == CNT_W'(TIMEOUT_TICKS));
   end

   // Command sequencer: byte collection, execute, transmit handshake, timeout
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_op      <= '0;
         r_tx_data     <= '0;
         r_tx_start    <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_overrun <= 1'b0;
      end else begin
         r_tx_start    <= 1'b0;
         r_err_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (RX_DONE) begin
                  r_alu_a <= RX_DATA;
                  r_state <= S_GET_B;
               end
            end
            // A byte arriving together with the terminal tick wins over the timeout
            S_GET_B: begin
               if (RX_DONE) begin
                  r_alu_b <= RX_DATA;
                  r_cnt   <= '0;
                  r_state <= S_GET_OP;
               end else if (TICK) begin
                  if (w_cnt_term) begin
                     r_cnt         <= '0;
                     r_err_timeout <= 1'b1;
                     r_state       <= S_IDLE;
                  end else begin
                     r_cnt <= w_cnt_next;
                  end
               end
            end
            S_GET_OP: begin
               if (RX_DONE) begin
                  r_alu_op <= RX_DATA[OP_W-1:0];
                  r_cnt    <= '0;
                  r_state  <= S_EXEC;
               end else if (TICK) begin
                  if (w_cnt_term) begin
                     r_cnt         <= '0;
                     r_err_timeout <= 1'b1;
                     r_state       <= S_IDLE;
                  end else begin
                     r_cnt <= w_cnt_next;
                  end
               end
            end
            // TX_START is registered here so it is high exactly while in SEND
            S_EXEC: begin
               r_cnt      <= '0;
               r_tx_data  <= ALU_RESULT;
               r_tx_start <= 1'b1;
               r_state    <= S_SEND;
               if (RX_DONE) r_err_overrun <= 1'b1;
            end
            S_SEND: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_TX;
               if (RX_DONE) r_err_overrun <= 1'b1;
            end
            S_WAIT_TX: begin
               r_cnt <= '0;
               if (RX_DONE) r_err_overrun <= 1'b1;
               if (TX_DONE) r_state <= S_IDLE;
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ALU_A       = r_alu_a;
   assign ALU_B       = r_alu_b;
   assign ALU_OP      = r_alu_op;
   assign TX_DATA     = r_tx_data;
   assign TX_START    = r_tx_start;
   assign BUSY        = (r_state != S_IDLE);
   assign ERR_TIMEOUT = r_err_timeout;
   assign ERR_OVERRUN = r_err_overrun;
   assign STATE       = r_state;

endmodule
